// File: rtl/fpcaccum.sv
// Complex fixed-point frame accumulator: sums up to LEN (re, im) products per frame
// in a guarded accumulator and emits one saturated complex sum per frame.
module fpcaccum #(
    parameter  int n   = 32,
    parameter  int d   = 16,
    parameter  int LEN = 8,
    localparam int G   = $clog2(LEN) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic         recv_last,
    input  logic [n-1:0] in_r,
    input  logic [n-1:0] in_c,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [n-1:0] sum_r,
    output logic [n-1:0] sum_c,
    output logic [G-1:0] sum_cnt,
    output logic         ovf
);

    // The binary point is carried by the data; addition never needs to know where it is.
    if (d < 0 || d >= n) begin : g_bad_frac
        $error("fpcaccum: fractional bits d must lie in [0, n)");
    end

    typedef enum logic {ACC, DONE} state_t;

    state_t             r_state;
    logic [n+G-1:0]     r_acc_r;
    logic [n+G-1:0]     r_acc_c;
    logic [G-1:0]       r_count;

    logic [n+G-1:0]     w_add_r;
    logic [n+G-1:0]     w_add_c;
    logic [n-1:0]       w_sat_r;
    logic [n-1:0]       w_sat_c;
    logic               w_clamp_r;
    logic               w_clamp_c;
    logic               w_accept;
    logic               w_close;
    logic               w_send;

    assign w_add_r  = r_acc_r + {{G{in_r[n-1]}}, in_r};
    assign w_add_c  = r_acc_c + {{G{in_c[n-1]}}, in_c};
    assign w_accept = recv_val && recv_rdy;
    assign w_close  = recv_last || (r_count == G'(LEN - 1));
    assign w_send   = send_val && send_rdy;

    // A value fits in n bits when every bit from n-1 upward equals the sign bit.
    function automatic logic clamps(input logic [n+G-1:0] x);
        return !((&x[n+G-1:n-1]) || !(|x[n+G-1:n-1]));
    endfunction

    function automatic logic [n-1:0] sat_n(input logic [n+G-1:0] x);
        if (!clamps(x))
            return x[n-1:0];
        else if (x[n+G-1])
            return {1'b1, {(n-1){1'b0}}};
        else
            return {1'b0, {(n-1){1'b1}}};
    endfunction

    assign w_clamp_r = clamps(w_add_r);
    assign w_clamp_c = clamps(w_add_c);
    assign w_sat_r   = sat_n(w_add_r);
    assign w_sat_c   = sat_n(w_add_c);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ACC;
            recv_rdy <= 1'b1;
            send_val <= 1'b0;
            r_acc_r  <= '0;
            r_acc_c  <= '0;
            r_count  <= '0;
            sum_r    <= '0;
            sum_c    <= '0;
            sum_cnt  <= '0;
            ovf      <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (w_accept) begin
                        r_acc_r <= w_add_r;
                        r_acc_c <= w_add_c;
                        r_count <= r_count + G'(1);
                        if (w_close) begin
                            sum_r    <= w_sat_r;
                            sum_c    <= w_sat_c;
                            sum_cnt  <= r_count + G'(1);
                            ovf      <= w_clamp_r || w_clamp_c;
                            recv_rdy <= 1'b0;
                            send_val <= 1'b1;
                            r_state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Result registers hold until the sum is taken downstream.
                    if (w_send) begin
                        r_acc_r  <= '0;
                        r_acc_c  <= '0;
                        r_count  <= '0;
                        recv_rdy <= 1'b1;
                        send_val <= 1'b0;
                        r_state  <= ACC;
                    end
                end
                default: begin
                    recv_rdy <= 1'b1;
                    send_val <= 1'b0;
                    r_state  <= ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpcaccum.sv
// Self-checking bench for fpcaccum: directed frames with literal results plus randomized
// complex products checked against a per-frame saturated-sum model.
module tb_fpcaccum;

    localparam int N = 32;
    localparam int L = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          recv_val = 1'b0;
    logic          recv_rdy;
    logic          recv_last = 1'b0;
    logic [N-1:0]  in_r = '0;
    logic [N-1:0]  in_c = '0;
    logic          send_val;
    logic          send_rdy = 1'b0;
    logic [N-1:0]  sum_r;
    logic [N-1:0]  sum_c;
    logic [3:0]    sum_cnt;
    logic          ovf;

    fpcaccum #(.n(N), .d(16), .LEN(L)) dut (
        .clk(clk), .reset(reset),
        .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_last(recv_last),
        .in_r(in_r), .in_c(in_c),
        .send_val(send_val), .send_rdy(send_rdy),
        .sum_r(sum_r), .sum_c(sum_c), .sum_cnt(sum_cnt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] r;
        logic [31:0] c;
        logic [3:0]  cnt;
        logic        ovf;
    } exp_t;

    exp_t   exp_q[$];
    longint acc_r_m = 0;
    longint acc_c_m = 0;
    int     cnt_m   = 0;
    bit     rnd_done = 1'b0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    function automatic bit clamps(input longint x);
        return (x > 64'sd2147483647) || (x < -64'sd2147483648);
    endfunction

    function automatic logic [31:0] sat32(input longint x);
        if (x > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (x < -64'sd2147483648) return 32'h8000_0000;
        return x[31:0];
    endfunction

    // Frame model: a frame closes on recv_last or on the L-th product.
    task automatic model_accept(input logic [31:0] r, input logic [31:0] c, input bit last);
        exp_t e;
        acc_r_m += longint'($signed(r));
        acc_c_m += longint'($signed(c));
        cnt_m++;
        if (last || cnt_m == L) begin
            e.r   = sat32(acc_r_m);
            e.c   = sat32(acc_c_m);
            e.cnt = cnt_m[3:0];
            e.ovf = clamps(acc_r_m) || clamps(acc_c_m);
            exp_q.push_back(e);
            acc_r_m = 0;
            acc_c_m = 0;
            cnt_m   = 0;
        end
    endtask

    task automatic model_reset();
        acc_r_m = 0;
        acc_c_m = 0;
        cnt_m   = 0;
        exp_q.delete();
    endtask

    // Offer one product; returns one time unit after the accepting edge.
    task automatic send_prod(input logic [31:0] r, input logic [31:0] c, input bit last);
        int waited;
        waited    = 0;
        recv_val  = 1'b1;
        in_r      = r;
        in_c      = c;
        recv_last = last;
        forever begin
            @(negedge clk);
            if (recv_rdy) break;
            waited++;
            if (waited > 200) begin
                check("recv_rdy_timeout", 0, 1);
                recv_val  = 1'b0;
                recv_last = 1'b0;
                return;
            end
        end
        @(posedge clk);
        model_accept(r, c, last);
        #1;
        recv_val  = 1'b0;
        recv_last = 1'b0;
    endtask

    task automatic check_sum(input string tag, input logic [31:0] r, input logic [31:0] c,
                             input logic [3:0] cnt, input logic o);
        check({tag, "_send_val"}, send_val, 1);
        check({tag, "_sum_r"}, sum_r, r);
        check({tag, "_sum_c"}, sum_c, c);
        check({tag, "_sum_cnt"}, sum_cnt, cnt);
        check({tag, "_ovf"}, ovf, o);
    endtask

    // Compare process: handshake flags and frame results every cycle out of reset.
    always @(negedge clk) begin
        if (reset) begin
            check("mon_recv_rdy", recv_rdy, (exp_q.size() == 0));
            check("mon_send_val", send_val, (exp_q.size() != 0));
            if (send_val && exp_q.size() > 0) begin
                check("mon_sum_r", sum_r, exp_q[0].r);
                check("mon_sum_c", sum_c, exp_q[0].c);
                check("mon_sum_cnt", sum_cnt, exp_q[0].cnt);
                check("mon_ovf", ovf, exp_q[0].ovf);
                if (send_rdy) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_recv_rdy", recv_rdy, 1);
        check("rst_send_val", send_val, 0);
        check("rst_sum_r", sum_r, 0);
        check("rst_sum_cnt", sum_cnt, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Full frame of eight (1.0 + 0.5j)
        send_rdy = 1'b1;
        for (int i = 0; i < 8; i++) send_prod(32'h0001_0000, 32'h0000_8000, 1'b0);
        @(negedge clk);
        check_sum("full", 32'h0008_0000, 32'h0004_0000, 4'd8, 1'b0);
        @(posedge clk); #1;

        // Early close after three (1.0 - 1.0j)
        for (int i = 0; i < 3; i++) send_prod(32'h0001_0000, 32'hFFFF_0000, i == 2);
        @(negedge clk);
        check_sum("early", 32'h0003_0000, 32'hFFFD_0000, 4'd3, 1'b0);
        @(posedge clk); #1;

        // Reset mid-frame after three products
        for (int i = 0; i < 3; i++) send_prod(32'h1234_0000, 32'h0000_0005, 1'b0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrst_recv_rdy", recv_rdy, 1);
        check("midrst_send_val", send_val, 0);
        check("midrst_sum_r", sum_r, 0);
        check("midrst_sum_c", sum_c, 0);
        check("midrst_sum_cnt", sum_cnt, 0);
        check("midrst_ovf", ovf, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        send_prod(32'h0001_0000, 32'h0001_0000, 1'b0);
        send_prod(32'h0004_0000, 32'h0000_0000, 1'b1);
        @(negedge clk);
        check_sum("postrst", 32'h0005_0000, 32'h0001_0000, 4'd2, 1'b0);
        @(posedge clk); #1;

        // Saturation on both components
        for (int i = 0; i < 8; i++) send_prod(32'h7FFF_0000, 32'h8000_0000, 1'b0);
        @(negedge clk);
        check_sum("sat", 32'h7FFF_FFFF, 32'h8000_0000, 4'd8, 1'b1);
        @(posedge clk); #1;

        // Backpressure: sum held ten cycles while the next product waits
        send_rdy = 1'b0;
        send_prod(32'h0001_0000, 32'h0002_0000, 1'b0);
        send_prod(32'h0003_0000, 32'hFFFF_0000, 1'b1);
        fork
            send_prod(32'h0005_0000, 32'h0000_0000, 1'b1);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("bp_recv_rdy", recv_rdy, 0);
                    check_sum("bp", 32'h0004_0000, 32'h0001_0000, 4'd2, 1'b0);
                end
                @(posedge clk); #1;
                send_rdy = 1'b1;
            end
        join
        @(negedge clk);
        check_sum("bp_next", 32'h0005_0000, 32'h0000_0000, 4'd1, 1'b0);
        @(posedge clk); #1;

        // Random Q16.16 complex products with gaps and random backpressure
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    int len;
                    len = int'($urandom_range(1, 10));
                    for (int i = 0; i < len; i++) begin
                        logic [31:0] pr, pc;
                        if ($urandom_range(0, 4) == 0) begin
                            pr = $urandom;
                            pc = $urandom;
                        end else begin
                            longint ar, ai, br, bi, xr, xc;
                            ar = longint'($urandom_range(0, 1048575)) - 524288;
                            ai = longint'($urandom_range(0, 1048575)) - 524288;
                            br = longint'($urandom_range(0, 1048575)) - 524288;
                            bi = longint'($urandom_range(0, 1048575)) - 524288;
                            xr = (ar * br - ai * bi) >>> 16;
                            xc = (ar * bi + ai * br) >>> 16;
                            pr = xr[31:0];
                            pc = xc[31:0];
                        end
                        send_prod(pr, pc, i == len - 1);
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk); #1;
                        end
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    send_rdy = ($urandom_range(0, 3) != 0);
                end
            end
        join
        send_rdy = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
